stream_mux_rr: RTL
==================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, >=1.
REQ-003 SHALL derive localparam SW = max(1, clog2(N_CH)): select/channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
REQ-007 SHALL have port in_valid  input  N_CH  per-channel request.
REQ-008 SHALL have port in_ready  output  N_CH  per-channel accept, at most one bit high.
REQ-009 SHALL have port force_en  input  1  1 = fixed-select mode, 0 = round-robin mode.
REQ-010 SHALL have port force_sel  input  SW  channel index used when force_en=1.
REQ-011 SHALL have port out_data  output  W  registered selected data.
REQ-012 SHALL have port out_ch  output  SW  index of channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  out_data/out_ch hold a word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when high with out_valid.

Function
REQ-015 SHALL hold a single-entry output register; load = (!out_valid || out_ready).
REQ-016 SHALL make in_ready combinational: in_ready[i] = load && grant[i].
REQ-017 SHALL compute grant one-hot: force_en=1 -> grant[force_sel] = in_valid[force_sel]; else round-robin over in_valid.
REQ-018 Round-robin SHALL search from channel (ptr+1) mod N_CH upward with wrap; first requesting channel wins.
REQ-019 ptr SHALL update to the granted index only on a transfer (in_valid[i] && in_ready[i]) with force_en=0.
REQ-020 ptr SHALL NOT change in force mode, so round-robin resumes where it left off.
REQ-021 force_sel >= N_CH SHALL produce grant = 0 and all in_ready low; out_valid unaffected except by drain.
REQ-022 On transfer, out_data and out_ch SHALL take the granted word and index next cycle, and out_valid SHALL be 1: latency 1 cycle.
REQ-023 If load=1 and no grant, out_valid SHALL be 0 next cycle; out_data/out_ch SHALL hold their previous values.
REQ-024 While out_valid && !out_ready, out_data, out_ch and out_valid SHALL be stable and in_ready SHALL be all 0.
REQ-025 Simultaneous drain and fill (out_valid && out_ready && grant != 0) SHALL sustain one word per cycle with no bubble.
REQ-026 force_en/force_sel changes SHALL take effect in the same cycle; no word SHALL be dropped or duplicated.

Reset
REQ-027 On rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=N_CH-1 (channel 0 has first priority).
REQ-028 rst SHALL override any transfer in the same cycle; a word held mid-operation SHALL be discarded.
REQ-029 in_ready SHALL be all 0 while rst=1.

Structure
REQ-030 SHALL place in a shared package stream_mux_pkg: the clog2 helper function and a MAX_CH=16 constant.
REQ-031 SHALL implement arbitration in one sub-module rr_arbiter (inputs: req[N_CH], ptr[SW]; output: grant one-hot[N_CH]).
REQ-032 Mode selection, output register and ptr update SHALL stay in stream_mux_rr.

Verification
REQ-033 Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000; first grant after release is ch0.
REQ-034 Round-robin fairness: N_CH=4, in_valid=1111, out_ready=1 -> out_ch sequence 0,1,2,3,0, one word per cycle.
REQ-035 Backpressure: out_ready=0 for 3 cycles with word 0xA5 held -> out_data stable at 0xA5, in_ready=0000; release -> next word next cycle.
REQ-036 Force mode: force_en=1, force_sel=2, in_valid=1111 -> out_ch=2 every cycle; return to force_en=0 after last RR grant ch1 -> next grant ch2.
REQ-037 Invalid select: N_CH=3, force_en=1, force_sel=3 -> in_ready=000, out_valid falls to 0 after drain.
REQ-038 Sparse requests: in_valid=0100 only, ptr=2 -> grant wraps to ch2, out_ch=2; mid-stream rst -> out_valid=0 next cycle.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream mux.
// Imported by the arbiter and the mux top.
package stream_mux_pkg;

  localparam int MAX_CH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap,
// first requesting channel wins; grant is one-hot or zero.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && req[i] &&
            i == (int'(ptr) + k) % N_CH) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with round-robin or forced selection
// feeding a single-entry registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int SW   = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              force_en,
  input  logic [SW-1:0]     force_sel,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [N_CH-1:0] rr_grant;
  logic [N_CH-1:0] grant;
  logic            load;
  logic            xfer;
  logic [SW-1:0]   sel_idx;
  logic [W-1:0]    sel_data;

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  rr_arbiter #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant)
  );

  // An out-of-range force_sel matches no channel, so grant stays 0.
  always_comb begin
    grant = '0;
    if (force_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (force_sel == SW'(i)) grant[i] = in_valid[i];
      end
    end else begin
      grant = rr_grant;
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_idx  = SW'(i);
        sel_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d  = xfer ? sel_data : out_data_q;
    out_ch_d    = xfer ? sel_idx : out_ch_q;
    ptr_d       = (xfer && !force_en) ? sel_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SW'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
